// File: rtl/aes_decipher_iter_pkg.sv
// Shared AES decipher types, key-length decode and GF(2^8) helpers.
package aes_decipher_iter_pkg;

    localparam int MAX_ROUNDS               = 14;
    localparam int MAX_EXPANSIONED_KEY_SIZE = 1920;

    typedef enum logic [1:0] {AES128, AES192, AES256, AES_KEY_ILLEGAL} aes_key_len_e;

    function automatic int nr_of(input aes_key_len_e kl);
        case (kl)
            AES192:  return 12;
            AES256:  return 14;
            default: return 10;
        endcase
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] res;
        logic [7:0] base;
        logic [7:0] e;
        res  = 8'h01;
        base = x;
        e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) res = gmul(res, base);
            base = gmul(base, base);
        end
        return res;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

endpackage

// File: rtl/inverse_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless final.
module inverse_round #(
    parameter bit LAST_ROUND = 1'b0
) (
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    output logic [127:0] state_o
);
    import aes_decipher_iter_pkg::*;

    // Byte n of the block sits at [127-8n -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++)
            o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c    -: 8];
            a1 = s[127-32*c-8  -: 8];
            a2 = s[127-32*c-16 -: 8];
            a3 = s[127-32*c-24 -: 8];
            o[127-32*c    -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
            o[127-32*c-8  -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
            o[127-32*c-16 -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
            o[127-32*c-24 -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
        end
        return o;
    endfunction

    logic [127:0] added;

    assign added   = inv_sub_bytes(inv_shift_rows(state_i)) ^ key_i;
    assign state_o = LAST_ROUND ? added : inv_mix_columns(added);

endmodule

// File: rtl/aes_decipher_iter.sv
// Iterative AES-128/192/256 decipher, ROUNDS_PER_CYCLE inverse rounds per clock, valid/ready on both sides.
module aes_decipher_iter #(
    parameter int DATA_WIDTH       = 128,
    parameter int MAX_ROUNDS       = aes_decipher_iter_pkg::MAX_ROUNDS,
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [1:0]                         in_key_len,
    input  logic [DATA_WIDTH-1:0]              cyphertext,
    input  logic [(MAX_ROUNDS+1)*DATA_WIDTH-1:0] round_keys,
    input  logic                               abort,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              plaintext,
    output logic                               key_err
);
    import aes_decipher_iter_pkg::*;

    localparam int KW    = (MAX_ROUNDS + 1) * DATA_WIDTH;
    localparam int RND_W = $clog2(MAX_ROUNDS + 1);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1 or 2");
    end
    if (DATA_WIDTH != 128 || KW > MAX_EXPANSIONED_KEY_SIZE) begin : g_bad_width
        $error("unsupported DATA_WIDTH / MAX_ROUNDS");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} st_e;

    st_e                   st_q, st_d;
    logic [DATA_WIDTH-1:0] state_q, state_d;
    logic [RND_W-1:0]      rnd_q, rnd_d;
    aes_key_len_e          kl_q, kl_d;
    logic [DATA_WIDTH-1:0] plaintext_q, plaintext_d;
    logic                  out_valid_q, out_valid_d;
    logic                  key_err_q, key_err_d;

    aes_key_len_e          kl_in;
    logic [DATA_WIDTH-1:0] key_nr;
    logic [ROUNDS_PER_CYCLE:0][DATA_WIDTH-1:0] chain;

    assign kl_in  = aes_key_len_e'(in_key_len);
    assign key_nr = round_keys[KW-1 - nr_of(kl_in)*DATA_WIDTH -: DATA_WIDTH];
    assign chain[0] = state_q;

    // Slot s uses key rnd_q-s; key 0 always lands in the last slot because Nr is even.
    for (genvar s = 0; s < ROUNDS_PER_CYCLE; s++) begin : g_slot
        logic [RND_W-1:0]      kidx, ksel;
        logic [DATA_WIDTH-1:0] rkey, mid_o, last_o;

        assign kidx = rnd_q - RND_W'(s);
        assign ksel = (kidx > RND_W'(MAX_ROUNDS)) ? '0 : kidx;
        assign rkey = round_keys[KW-1 - int'(ksel)*DATA_WIDTH -: DATA_WIDTH];

        inverse_round #(.LAST_ROUND(1'b0)) u_mid  (.state_i(chain[s]), .key_i(rkey), .state_o(mid_o));
        inverse_round #(.LAST_ROUND(1'b1)) u_last (.state_i(chain[s]), .key_i(rkey), .state_o(last_o));

        assign chain[s+1] = (kidx == '0) ? last_o : mid_o;
    end

    always_comb begin
        st_d        = st_q;
        state_d     = state_q;
        rnd_d       = rnd_q;
        kl_d        = kl_q;
        plaintext_d = plaintext_q;
        out_valid_d = out_valid_q;
        key_err_d   = key_err_q;
        case (st_q)
            IDLE: if (in_valid) begin
                if (kl_in == AES_KEY_ILLEGAL) begin
                    plaintext_d = '0;
                    key_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    st_d        = DONE;
                end else begin
                    state_d = cyphertext ^ key_nr;
                    rnd_d   = RND_W'(nr_of(kl_in) - 1);
                    kl_d    = kl_in;
                    st_d    = RUN;
                end
            end
            RUN: begin
                state_d = chain[ROUNDS_PER_CYCLE];
                rnd_d   = rnd_q - RND_W'(ROUNDS_PER_CYCLE);
                if (rnd_q == RND_W'(ROUNDS_PER_CYCLE - 1)) begin
                    plaintext_d = chain[ROUNDS_PER_CYCLE];
                    out_valid_d = 1'b1;
                    key_err_d   = 1'b0;
                    st_d        = DONE;
                end
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                st_d        = IDLE;
            end
            default: st_d = IDLE;
        endcase
        // Flush overrides any accept or output handshake in the same cycle.
        if (abort) begin
            st_d        = IDLE;
            out_valid_d = 1'b0;
            key_err_d   = 1'b0;
            plaintext_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= IDLE;
            state_q     <= '0;
            rnd_q       <= '0;
            kl_q        <= AES128;
            plaintext_q <= '0;
            out_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            st_q        <= st_d;
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            kl_q        <= kl_d;
            plaintext_q <= plaintext_d;
            out_valid_q <= out_valid_d;
            key_err_q   <= key_err_d;
        end
    end

    always_comb begin
        if (st_q == RUN) assert (int'(rnd_q) < nr_of(kl_q));
    end

    assign in_ready  = (st_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign plaintext = plaintext_q;
    assign key_err   = key_err_q;

endmodule

// File: tb/tb_aes_decipher_iter.sv
// FIPS-197 known-answer bench for aes_decipher_iter with a scoreboard and corner-case sequences.
module tb_aes_decipher_iter;

    localparam int RPC = 1;
    localparam int KW  = 15 * 128;

    localparam logic [255:0] KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_key_len = 2'd0;
    logic [127:0]  cyphertext = '0;
    logic [KW-1:0] round_keys = '0;
    logic          abort = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [127:0]  plaintext;
    logic          key_err;

    aes_decipher_iter #(.DATA_WIDTH(128), .MAX_ROUNDS(14), .ROUNDS_PER_CYCLE(RPC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_key_len(in_key_len), .cyphertext(cyphertext), .round_keys(round_keys),
        .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
        .plaintext(plaintext), .key_err(key_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] kl; logic [127:0] ct; logic [127:0] pt; logic ke; int lat; } vec_t;
    typedef struct { logic [127:0] pt; logic ke; int lat; } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [KW-1:0] rk128, rk192, rk256;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Reference key expansion built on the forward S-box.
    function automatic logic [7:0] b_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] b_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0; x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = b_xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] b_sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = b_mul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {b_sbox(w[31:24]), b_sbox(w[23:16]), b_sbox(w[15:8]), b_sbox(w[7:0])};
    endfunction

    function automatic logic [KW-1:0] expand(input int nk, input int nr);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [KW-1:0] rk;
        for (int i = 0; i < KW/32; i++) rk[i*32 +: 32] = $urandom;
        rc = 8'h01;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) w[i] = KEY[255-32*i -: 32];
            else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = b_xt(rc);
                end else if (nk > 6 && i % nk == 4) t = subw(t);
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int k = 0; k <= nr; k++)
            rk[KW-1-128*k -: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return rk;
    endfunction

    task automatic send(input logic [1:0] kl, input logic [127:0] ct, input bit push,
                        input logic [127:0] pt, input logic ke, input int lat);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("in_ready_wait", in_ready, 1'b1);
        in_valid   = 1'b1;
        in_key_len = kl;
        cyphertext = ct;
        round_keys = (kl == 2'd1) ? rk192 : (kl == 2'd2) ? rk256 : rk128;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) begin
            e.pt = pt; e.ke = ke; e.lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: output with no expected entry");
            return;
        end
        e = sb.pop_front();
        check("out_valid", out_valid, 1'b1);
        check("latency", lat, e.lat);
        check("plaintext", plaintext, e.pt);
        check("key_err", key_err, e.ke);
        for (int i = 0; i < hold; i++) begin
            in_valid   = 1'b1;
            in_key_len = 2'd3;
            @(posedge clk); #1;
            check("hold_pt", plaintext, e.pt);
            check("hold_ov", out_valid, 1'b1);
            check("hold_ir", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_ov", out_valid, 1'b0);
        check("post_ir", in_ready, 1'b1);
    endtask

    initial begin
        vec_t vecs[5];
        bit   seen;

        rk128 = expand(4, 10);
        rk192 = expand(6, 12);
        rk256 = expand(8, 14);
        vecs[0] = '{2'd0, CT128, PT, 1'b0, 10/RPC};
        vecs[1] = '{2'd1, CT192, PT, 1'b0, 12/RPC};
        vecs[2] = '{2'd2, CT256, PT, 1'b0, 14/RPC};
        vecs[3] = '{2'd3, CT128, 128'h0, 1'b1, 0};
        vecs[4] = '{2'd0, CT128, PT, 1'b0, 10/RPC};

        #1;
        check("rst_ov", out_valid, 1'b0);
        check("rst_pt", plaintext, 128'h0);
        check("rst_ke", key_err, 1'b0);
        check("rst_ir", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ir", in_ready, 1'b1);

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].kl, vecs[i].ct, 1'b1, vecs[i].pt, vecs[i].ke, vecs[i].lat);
            collect(0);
        end

        // Output backpressure with stray in_valid while DONE.
        send(2'd2, CT256, 1'b1, PT, 1'b0, 14/RPC);
        collect(20);

        // Back-to-back mixed key lengths.
        send(2'd1, CT192, 1'b1, PT, 1'b0, 12/RPC); collect(0);
        send(2'd0, CT128, 1'b1, PT, 1'b0, 10/RPC); collect(0);
        send(2'd2, CT256, 1'b1, PT, 1'b0, 14/RPC); collect(0);

        // Abort during RUN cycle 4.
        send(2'd0, CT128, 1'b0, PT, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_ir", in_ready, 1'b1);
        check("abort_ov", out_valid, 1'b0);
        check("abort_pt", plaintext, 128'h0);
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("abort_no_ov", seen, 1'b0);
        send(2'd0, CT128, 1'b1, PT, 1'b0, 10/RPC); collect(0);

        // Asynchronous reset pulse mid-RUN, off the clock edge.
        send(2'd1, CT192, 1'b0, PT, 1'b0, 0);
        repeat (3) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        check("arst_ov", out_valid, 1'b0);
        check("arst_pt", plaintext, 128'h0);
        check("arst_ke", key_err, 1'b0);
        check("arst_ir", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_rel_ir", in_ready, 1'b1);
        @(posedge clk); #1;
        send(2'd0, CT128, 1'b1, PT, 1'b0, 10/RPC); collect(0);
        send(2'd2, CT256, 1'b1, PT, 1'b0, 14/RPC); collect(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_decipher_iter.md
Name: aes_decipher_iter

Overview:
- Parametrised, iterative successor to the fully unrolled AES decipher.
- Runtime-selectable AES-128/192/256 (Nr = 10/12/14), executing ROUNDS_PER_CYCLE inverse rounds per clock.
- Valid/ready handshake on both input and output sides, plus a synchronous abort.
- Sits between the key-expansion block, which supplies all round keys, and the system bus / mode-of-operation wrapper.

Parameters:
- DATA_WIDTH, 128, block width; fixed by AES.
- MAX_ROUNDS, 14, largest Nr supported; sizes the round-key bus.
- ROUNDS_PER_CYCLE, 1, inverse rounds per clock; legal values 1 or 2 (Nr is always even). Any other value causes an elaboration error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  a block is offered.
- in_ready  out  1  block accepted when in_valid & in_ready.
- in_key_len  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=illegal.
- cyphertext  in  DATA_WIDTH  input block.
- round_keys  in  (MAX_ROUNDS+1)*DATA_WIDTH  packed keys. Key k = round_keys[top - k*128 -: 128], k = 0..Nr. Upper-packed; unused low keys are ignored.
- abort  in  1  synchronous flush.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- plaintext  out  DATA_WIDTH  decrypted block.
- key_err  out  1  qualifies out_valid; result came from an illegal in_key_len.

Behaviour:
- Reset (rst=1, async): state=IDLE, out_valid=0, plaintext=0, key_err=0, in_ready=0 (in_ready = IDLE & !rst).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On accept with a legal key_len: state_q <= cyphertext ^ key[Nr], rnd_q <= Nr-1, kl_q <= in_key_len, go to RUN.
  - On accept with key_len=11: plaintext <= 0, key_err <= 1, out_valid <= 1, go to DONE, no rounds executed.
- RUN:
  - Each cycle applies ROUNDS_PER_CYCLE inverse rounds using keys rnd_q, rnd_q-1, ...
  - The round using key 0 is the final round: no InvMixColumns.
  - rnd_q decrements by ROUNDS_PER_CYCLE each cycle.
  - In the cycle that processes key 0: plaintext <= result, out_valid <= 1, key_err <= 0, go to DONE.
- Latency: accept cycle = cycle 0; out_valid rises in cycle Nr/ROUNDS_PER_CYCLE.
  - ROUNDS_PER_CYCLE=1: 10/12/14 cycles.
  - ROUNDS_PER_CYCLE=2: 5/6/7 cycles.
- DONE:
  - out_valid and plaintext held stable until out_ready.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE.
  - in_ready=0 in DONE; a new accept is possible at the earliest one cycle after the handshake.
- round_keys and in_key_len are not registered, except kl_q. The source holds round_keys stable from accept until out_valid; the block does not check this.
- in_valid outside IDLE is ignored, with no side effect.
- abort (any state, no effect while rst=1): next state IDLE, out_valid=0, key_err=0, plaintext=0. abort wins over a simultaneous accept or output handshake.
- Reset asserted mid-RUN: the operation is discarded with no partial output. After release the block is in IDLE.
- plaintext changes only on completion, an illegal-key completion, abort or reset.

Decomposition:
- Add to aes_package:
  - MAX_ROUNDS=14.
  - MAX_EXPANSIONED_KEY_SIZE=1920.
  - typedef enum logic [1:0] aes_key_len_e {AES128, AES192, AES256, AES_KEY_ILLEGAL}.
  - function nr_of(aes_key_len_e) returning 10/12/14.
- FSM state enum stays local.
- Sub-module: reuse the existing inverse_round. For each of the ROUNDS_PER_CYCLE slots, instantiate LAST_ROUND=0 and LAST_ROUND=1 variants, muxed on (key index == 0).
- No new sub-module is needed; the round-key selector is an inline indexed part-select.

Test Plan (FIPS-197 App. C vectors, round keys from the bench key-expansion model; expected plaintext 00112233445566778899aabbccddeeff):
- AES-128: key 000102..0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> correct plaintext, out_valid at cycle 10 (5 when ROUNDS_PER_CYCLE=2), key_err=0.
- AES-192: key 000102..17, ct dda97ca4864cdfe06eaf70a0ec0d7191; and AES-256: key 000102..1f, ct 8ea2b7ca516745bfeafc49904b496089 -> correct plaintext, latency 12/14 cycles (6/7 when ROUNDS_PER_CYCLE=2).
- Backpressure: hold out_ready=0 for 20 cycles after completion -> plaintext and out_valid stable, in_ready=0; raise out_ready -> IDLE next cycle; back-to-back blocks of mixed key lengths all match.
- Illegal in_key_len=11 -> out_valid the next cycle, key_err=1, plaintext=0; the following legal block decodes correctly.
- abort asserted in RUN cycle 4 -> out_valid never rises, in_ready=1 the next cycle, plaintext=0; the next AES-128 block is correct.
- Async rst pulse mid-RUN, not clock-aligned -> outputs 0 immediately; after release, in_ready=1 and the subsequent decrypt is correct.
